shift_sched: RTL and testbench
==============================

# shift_sched

Multi-cycle scheduler for the CPU's 32-bit shift unit. It arbitrates between two requesters, then runs the shift as a five-step sequence of power-of-two stages (16, 8, 4, 2, 1), one stage per clock, through a single registered accumulator. The requesters are port 0 (ALU issue) and port 1 (load/store byte-alignment path). It returns the result with its requester ID over a valid/ready response channel, and sits beside the ALU in the execute stage.

## Interface
- No parameters; data width fixed at 32, shift amount fixed at 5 bits, two requesters.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (low on a rising clk edge resets the block)
- req0_valid  in  1  port 0 request present
- req0_ready  out  1  port 0 request accepted this cycle
- req0_shamt  in  5  port 0 shift amount
- req0_ctrl  in  2  port 0 op: 00 SLL, 01 SRL, 11 SRA, 10 pass-through
- req0_data  in  32  port 0 operand
- req1_valid, req1_ready, req1_shamt, req1_ctrl, req1_data: same as port 0, for port 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  shifted result
- rsp_id  out  1  requester that issued the result (0/1)
- busy  out  1  high whenever state is not IDLE

## Operation
- States:
  - IDLE: arbitrate and accept one request.
  - RUN: step counter k counts 4 down to 0.
  - DONE: hold result until rsp_ready.
- IDLE arbitration:
  - reqN_ready is combinational and asserts only for the granted port, only in IDLE, and only while reset is high.
  - Single valid port wins.
  - Both valid: grant the port not served last (round-robin pointer, updated on each accept).
  - After reset, the pointer favours port 0.
- Accept (valid & ready): capture data into acc, plus shamt, ctrl and id; go to RUN with k=4.
- RUN step k, applied only if shamt[k]=1:
  - SLL: acc <<= 2^k, zero fill.
  - SRL: acc >>= 2^k, zero fill.
  - SRA: acc >>= 2^k, filled with acc[31].
  - 10 (pass-through): acc unchanged.
- After step k=0, go to DONE.
- DONE:
  - rsp_valid=1; rsp_data=acc and rsp_id are stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
  - No new request is accepted in DONE (no bypass).
- Arithmetic is modulo 2^32; shamt is interpreted as 0..31.
- A request's inputs are sampled only at acceptance; later changes to them are ignored.

## Timing
- Reset values: state IDLE; rsp_valid 0; rsp_data 0x0000_0000; rsp_id 0; busy 0; req0_ready and req1_ready 0 during the reset cycle; RR pointer favours port 0.
- Reset mid-RUN or in DONE: the operation is discarded, the next state is IDLE and no response is produced.
- Latency, with acceptance in cycle 0:
  - RUN occupies cycles 1–5.
  - rsp_valid rises in cycle 6.
- Throughput: if rsp_ready=1 in cycle 6, IDLE is reached in cycle 7 and a new request can be accepted there. Minimum issue period is 7 cycles.
- rsp_ready held low: the block stays in DONE indefinitely and busy stays 1.
- busy=1 from cycle 1 through the response handshake cycle.

## Configuration
- Macro: SHIFT_SKIP_EN.
- Undefined: fixed 5-cycle RUN as above, regardless of shamt.
- Defined:
  - RUN visits only the set bits of shamt, highest first.
  - shamt=0 or ctrl=10 goes from IDLE directly to DONE.
  - rsp_valid rises in cycle 1+popcount(shamt), or in cycle 1 for the two direct cases.
  - Results are identical to the undefined build; only latency differs.

## Test plan
- Port 0 SLL: data 0x0000_00F1, shamt 4 -> rsp_data 0x0000_0F10, rsp_id 0, rsp_valid in cycle 6.
- Port 1 SRA: data 0x8000_0000, shamt 31 -> 0xFFFF_FFFF. Port 1 SRL with the same data and shamt -> 0x0000_0001. Port 1 ctrl 10, data 0x1234_5678, shamt 7 -> 0x1234_5678. All with rsp_id 1.
- Both ports valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; no port is granted twice in a row while the other waits.
- rsp_ready held low for 10 cycles after rsp_valid -> rsp_data/rsp_id stable, both readies 0, busy 1. Release -> IDLE next cycle.
- reset driven low in RUN cycle 3 -> next cycle: state IDLE, rsp_valid 0, busy 0. No stale response appears afterwards.
- SHIFT_SKIP_EN defined: shamt 0b10001 SLL of 0x1 -> 0x0002_0000 in cycle 3. shamt 0 -> original data in cycle 1.

Source files
------------

// File: rtl/shift_sched.sv
// Two-port scheduler for the 32-bit shifter: round-robin accept, a 16/8/4/2/1 stage walk through one accumulator, valid/ready response.
// Optional SHIFT_SKIP_EN: visit only the set bits of shamt; shamt 0 or pass-through goes straight to DONE.
//
// state | meaning
// IDLE  | arbitrate between ports, accept one request
// RUN   | apply stage k (2^k shift) to acc, k walks downward
// DONE  | hold result on rsp_* until rsp_ready
module shift_sched (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_shamt,
   input  logic [1:0]  req0_ctrl,
   input  logic [31:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_shamt,
   input  logic [1:0]  req1_ctrl,
   input  logic [31:0] req1_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [2:0]  k, k_nx;
   logic [31:0] acc, acc_nx;
   logic [4:0]  shamt_q, shamt_nx;
   logic [1:0]  ctrl_q, ctrl_nx;
   logic        id_q, id_nx;
   logic        rr_q, rr_nx;
   logic        grant0, grant1, accept;
   logic [4:0]  sel_shamt;
   logic [1:0]  sel_ctrl;
   logic [31:0] sel_data;

   function automatic logic [31:0] shift_step(input logic [31:0] a,
                                              input logic [1:0]  op,
                                              input logic [2:0]  kk);
      logic [4:0] amt;
      amt = 5'd1 << kk;
      case (op)
         2'b00:   return a << amt;
         2'b01:   return a >> amt;
         2'b11:   return $unsigned($signed(a) >>> amt);
         default: return a;
      endcase
   endfunction

`ifdef SHIFT_SKIP_EN
   function automatic logic [2:0] top_bit(input logic [4:0] m);
      logic [2:0] t;
      t = 3'd0;
      for (int i = 0; i < 5; i++)
         if (m[i]) t = 3'(i);
      return t;
   endfunction

   logic [4:0] rest;
`endif

   // rr_q names the port preferred when both are valid
   assign grant0 = reset && (state == IDLE) && req0_valid && (!req1_valid || !rr_q);
   assign grant1 = reset && (state == IDLE) && req1_valid && (!req0_valid ||  rr_q);
   assign accept = grant0 || grant1;

   assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
   assign sel_ctrl  = grant1 ? req1_ctrl  : req0_ctrl;
   assign sel_data  = grant1 ? req1_data  : req0_data;

   always_comb begin
      state_nx = state;
      k_nx     = k;
      acc_nx   = acc;
      shamt_nx = shamt_q;
      ctrl_nx  = ctrl_q;
      id_nx    = id_q;
      rr_nx    = rr_q;
`ifdef SHIFT_SKIP_EN
      rest     = 5'd0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               id_nx    = grant1;
               rr_nx    = grant0;
               acc_nx   = sel_data;
               shamt_nx = sel_shamt;
               ctrl_nx  = sel_ctrl;
`ifdef SHIFT_SKIP_EN
               if (sel_shamt == 5'd0 || sel_ctrl == 2'b10) begin
                  state_nx = DONE;
                  k_nx     = 3'd0;
               end else begin
                  state_nx = RUN;
                  k_nx     = top_bit(sel_shamt);
               end
`else
               state_nx = RUN;
               k_nx     = 3'd4;
`endif
            end
         end
         RUN: begin
`ifdef SHIFT_SKIP_EN
            acc_nx = shift_step(acc, ctrl_q, k);
            rest   = shamt_q & ((5'd1 << k) - 5'd1);
            if (rest == 5'd0) state_nx = DONE;
            else              k_nx     = top_bit(rest);
`else
            if (shamt_q[k]) acc_nx = shift_step(acc, ctrl_q, k);
            if (k == 3'd0) state_nx = DONE;
            else           k_nx     = k - 3'd1;
`endif
         end
         DONE: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         k       <= 3'd0;
         acc     <= 32'd0;
         shamt_q <= 5'd0;
         ctrl_q  <= 2'd0;
         id_q    <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         k       <= k_nx;
         acc     <= acc_nx;
         shamt_q <= shamt_nx;
         ctrl_q  <= ctrl_nx;
         id_q    <= id_nx;
         rr_q    <= rr_nx;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp_valid  = (state == DONE);
   assign rsp_data   = acc;
   assign rsp_id     = id_q;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed cases plus randomized traffic against a spec-level model.
// Honours SHIFT_SKIP_EN for expected latency.
module tb_shift_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_shamt, req1_shamt;
   logic [1:0]  req0_ctrl, req1_ctrl;
   logic [31:0] req0_data, req1_data;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [31:0] rsp_data;

   int checks   = 0;
   int failures = 0;
   bit rr_pref  = 1'b0;

   shift_sched dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_shamt(req0_shamt),
      .req0_ctrl(req0_ctrl), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_shamt(req1_shamt),
      .req1_ctrl(req1_ctrl), .req1_data(req1_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] c, input logic [4:0] s,
                                             input logic [31:0] d);
      case (c)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b11:   return $unsigned($signed(d) >>> s);
         default: return d;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] c, input logic [4:0] s);
`ifdef SHIFT_SKIP_EN
      if (s == 5'd0 || c == 2'b10) return 1;
      return 1 + $countones(s);
`else
      return 6;
`endif
   endfunction

   task automatic scramble();
      req0_shamt = 5'($urandom);  req1_shamt = 5'($urandom);
      req0_ctrl  = 2'($urandom);  req1_ctrl  = 2'($urandom);
      req0_data  = $urandom;      req1_data  = $urandom;
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first IDLE cycle after the handshake.
   task automatic txn(input bit v0, input bit v1,
                      input logic [1:0] c0, input logic [4:0] s0, input logic [31:0] d0,
                      input logic [1:0] c1, input logic [4:0] s1, input logic [31:0] d1,
                      input bit keep, input int hold);
      int g, lat, c;
      logic [31:0] exp_d;
      req0_valid = v0; req0_ctrl = c0; req0_shamt = s0; req0_data = d0;
      req1_valid = v1; req1_ctrl = c1; req1_shamt = s1; req1_data = d1;
      rsp_ready  = (hold == 0);
      #1;
      if (v0 && v1) g = rr_pref;
      else          g = v1 ? 1 : 0;
      check("grant0", req0_ready, 32'(g == 0));
      check("grant1", req1_ready, 32'(g == 1));
      exp_d   = (g == 1) ? ref_shift(c1, s1, d1) : ref_shift(c0, s0, d0);
      lat     = (g == 1) ? ref_latency(c1, s1) : ref_latency(c0, s0);
      rr_pref = (g == 0);
      tick();
      c = 1;
      if (!keep) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      scramble();
      #1;
      check("busy_c1", busy, 1);
      check("rdy_c1", {req0_ready, req1_ready}, 0);
      while (!rsp_valid && c < 20) begin
         tick();
         c++;
      end
      check("latency", c, lat);
      check("rsp_data", rsp_data, exp_d);
      check("rsp_id", rsp_id, g);
      if (hold > 0) begin
         repeat (hold) begin
            tick();
            check("hold_data", rsp_data, exp_d);
            check("hold_id", rsp_id, g);
            check("hold_valid", rsp_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_rdy", {req0_ready, req1_ready}, 0);
         end
         rsp_ready = 1'b1;
      end
      tick();
      check("idle_busy", busy, 0);
      check("idle_valid", rsp_valid, 0);
   endtask

   initial begin
      reset = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      scramble();
      tick();
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("rst_rdy", {req0_ready, req1_ready}, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rsp_data, 0);
      check("rst_id", rsp_id, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b1;
      #1;

      // Directed operations
      txn(1, 0, 2'b00, 5'd4,  32'h0000_00F1, 2'b00, 5'd0, 32'h0, 0, 0);
      txn(0, 1, 2'b00, 5'd0,  32'h0,         2'b11, 5'd31, 32'h8000_0000, 0, 0);
      txn(0, 1, 2'b00, 5'd0,  32'h0,         2'b01, 5'd31, 32'h8000_0000, 0, 0);
      txn(0, 1, 2'b00, 5'd0,  32'h0,         2'b10, 5'd7,  32'h1234_5678, 0, 0);
      txn(1, 0, 2'b00, 5'b10001, 32'h1,      2'b00, 5'd0, 32'h0, 0, 0);
      txn(1, 0, 2'b11, 5'd0,  32'hCAFE_F00D, 2'b00, 5'd0, 32'h0, 0, 0);
      txn(1, 0, 2'b11, 5'd5,  32'h7F00_0000, 2'b00, 5'd0, 32'h0, 0, 0);

      // Both ports valid every cycle: grants must alternate
      for (int i = 0; i < 6; i++)
         txn(1, 1, 2'($urandom), 5'($urandom), $urandom,
                   2'($urandom), 5'($urandom), $urandom, 1, 0);

      // Back-pressure on the response
      txn(1, 1, 2'b01, 5'd9, 32'hDEAD_BEEF, 2'b00, 5'd3, 32'h0F0F_0F0F, 1, 10);

      // Randomized traffic
      for (int i = 0; i < 12; i++) begin
         int v;
         v = $urandom_range(1, 3);
         txn(v[0], v[1], 2'($urandom), 5'($urandom), $urandom,
                         2'($urandom), 5'($urandom), $urandom,
             1'($urandom), $urandom_range(0, 3));
      end

      // Reset during RUN: pointer currently favours port 1 after this accept of port 0
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_ctrl = 2'b00; req0_shamt = 5'd31; req0_data = 32'hFFFF_FFFF;
      rsp_ready  = 1'b1;
      #1;
      check("rr_rst_acc", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      req0_valid = 1'b1;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_data", rsp_data, 0);
      check("mid_rst_rdy", req0_ready, 0);
      reset = 1'b1;
      req0_valid = 1'b0;
      rr_pref = 1'b0;
      begin
         int stale;
         stale = 0;
         repeat (10) begin
            tick();
            if (rsp_valid) stale++;
         end
         check("no_stale_rsp", stale, 0);
      end
      txn(1, 1, 2'b01, 5'd1, 32'h0000_0100, 2'b00, 5'd1, 32'h1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
